// File: rtl/mem_port_arbiter_if.sv
// One requester port of the memory arbiter: request with address/data, registered read data and ack.
// The requester holds req, we, addr and wdata stable until ack, then drops req the next cycle.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving a CPU port and a DMA port turns on one single-ported memory.
// Grant to ack takes MEM_LAT+1 cycles; a port waits, holding req, while the other port owns the memory.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave dma,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;
  xfer_t             xfer_q, xfer_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              grant_dma;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    xfer_d       = xfer_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    grant_dma    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu.req || dma.req) begin
          // On a tie the port that did not own the previous access wins.
          grant_dma    = dma.req && (!cpu.req || !last_owner_q);
          xfer_d.owner = grant_dma;
          xfer_d.we    = grant_dma ? dma.we    : cpu.we;
          xfer_d.addr  = grant_dma ? dma.addr  : cpu.addr;
          xfer_d.wdata = grant_dma ? dma.wdata : cpu.wdata;
          cnt_d        = CNT_INIT;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_addr  = xfer_q.addr;
        mem_wdata = xfer_q.wdata;
        mem_read  = !xfer_q.we;
        mem_write = xfer_q.we && (cnt_q == CNT_INIT);
        if (cnt_q == '0) begin
          if (!xfer_q.we) begin
            if (xfer_q.owner) dma_rdata_d = mem_rdata;
            else              cpu_rdata_d = mem_rdata;
          end
          last_owner_d = xfer_q.owner;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
      xfer_q       <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      xfer_q       <= xfer_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu.ack   = (state_q == S_DONE) && !xfer_q.owner;
  assign dma.ack   = (state_q == S_DONE) &&  xfer_q.owner;
  assign cpu.rdata = cpu_rdata_q;
  assign dma.rdata = dma_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = xfer_q.owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model; a second instance covers MEM_LAT=1.
module tb_mem_port_arbiter;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dma_a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_b ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dma_b ();

  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        mem_read_a, mem_write_a, busy_a, owner_a;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        mem_read_b, mem_write_b, busy_b, owner_b;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .cpu(cpu_a), .dma(dma_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_rdata(mem_rdata_a), .busy(busy_a), .owner(owner_a)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .cpu(cpu_b), .dma(dma_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .owner(owner_b)
  );

  function automatic logic [31:0] init_word(int i);
    logic [31:0] w;
    w = 32'(i);
    return (i == 4) ? 32'h1234_5678 : (32'h3C00_00A5 ^ (w << 8) ^ (w << 20));
  endfunction

  // Memory macros: read data is only valid in the last cycle of a read burst.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  int          rd_run_a;
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] <= init_word(i);
      mem_b[i] <= init_word(i);
    end
    rd_run_a <= 0;
    forever begin
      @(posedge clk);
      if (mem_write_a) mem_a[mem_addr_a[7:2]] <= mem_wdata_a;
      if (mem_write_b) mem_b[mem_addr_b[7:2]] <= mem_wdata_b;
      rd_run_a <= mem_read_a ? rd_run_a + 1 : 0;
    end
  end
  assign mem_rdata_a = (mem_read_a && rd_run_a == LAT_A - 1) ? mem_a[mem_addr_a[7:2]] : 32'h0BAD_0BAD;
  assign mem_rdata_b = mem_read_b ? mem_b[mem_addr_b[7:2]] : 32'h0BAD_0BAD;

  int checks   = 0;
  int failures = 0;

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: one access in flight, tracked by its phase since grant.
  logic        model_en = 1'b0;
  logic        m_act, m_own, m_we, m_last, m_owner;
  int          m_ph;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rd [2];
  logic [31:0] ref_mem [64];
  logic        cack_prev = 1'b0;
  logic        dack_prev = 1'b0;

  task automatic model_reset();
    m_act = 1'b0; m_ph = 0; m_last = 1'b1; m_owner = 1'b0; m_own = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic model_cycle();
    logic in_acc, done, e_wr;
    cack_prev = cpu_a.ack;
    dack_prev = dma_a.ack;
    if (!model_en) return;
    in_acc = m_act && m_ph <= LAT_A;
    done   = m_act && m_ph == LAT_A + 1;
    e_wr   = in_acc && m_we && m_ph == 1;
    chk1 ("m_busy",      busy_a,      m_act);
    chk1 ("m_owner",     owner_a,     m_owner);
    chk1 ("m_mem_read",  mem_read_a,  in_acc && !m_we);
    chk1 ("m_mem_write", mem_write_a, e_wr);
    chk32("m_mem_addr",  mem_addr_a,  in_acc ? m_addr  : 32'd0);
    chk32("m_mem_wdata", mem_wdata_a, in_acc ? m_wdata : 32'd0);
    chk1 ("m_cpu_ack",   cpu_a.ack,   done && !m_own);
    chk1 ("m_dma_ack",   dma_a.ack,   done && m_own);
    chk32("m_cpu_rdata", cpu_a.rdata, m_rd[0]);
    chk32("m_dma_rdata", dma_a.rdata, m_rd[1]);
    if (e_wr) ref_mem[m_addr[7:2]] = m_wdata;
    if (rst) begin
      model_reset();
    end else if (m_act) begin
      if (m_ph == LAT_A) begin
        if (!m_we) m_rd[m_own] = ref_mem[m_addr[7:2]];
        m_last = m_own;
      end
      m_ph++;
      if (m_ph > LAT_A + 1) m_act = 1'b0;
    end else if (cpu_a.req || dma_a.req) begin
      m_own   = (cpu_a.req && dma_a.req) ? !m_last : dma_a.req;
      m_we    = m_own ? dma_a.we    : cpu_a.we;
      m_addr  = m_own ? dma_a.addr  : cpu_a.addr;
      m_wdata = m_own ? dma_a.wdata : cpu_a.wdata;
      m_owner = m_own;
      m_act   = 1'b1;
      m_ph    = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive(input logic ack_prev, input logic req_i, input logic we_i,
                            input logic [31:0] a_i, input logic [31:0] w_i,
                            output logic req_o, output logic we_o,
                            output logic [31:0] a_o, output logic [31:0] w_o);
    req_o = req_i; we_o = we_i; a_o = a_i; w_o = w_i;
    if (req_i) begin
      if (ack_prev) req_o = 1'b0;
    end else begin
      we_o = 1'($urandom_range(0, 1));
      a_o  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      w_o  = $urandom;
      if ($urandom_range(0, 2) == 0) req_o = 1'b1;
    end
  endtask

  initial begin
    logic        rq, w;
    logic [31:0] a, d;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    cpu_b.req = 0; cpu_b.we = 0; cpu_b.addr = 0; cpu_b.wdata = 0;
    dma_b.req = 0; dma_b.we = 0; dma_b.addr = 0; dma_b.wdata = 0;

    // Reset held two cycles with both ports requesting.
    rst = 1'b1;
    cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 32'h10; cpu_a.wdata = 32'h0;
    dma_a.req = 1; dma_a.we = 1; dma_a.addr = 32'h20; dma_a.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    model_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk1 ("rst_busy", busy_a, 1'b0);       chk1("rst_owner", owner_a, 1'b0);
      chk1 ("rst_cack", cpu_a.ack, 1'b0);    chk1("rst_dack", dma_a.ack, 1'b0);
      chk1 ("rst_mrd", mem_read_a, 1'b0);    chk1("rst_mwr", mem_write_a, 1'b0);
      chk32("rst_maddr", mem_addr_a, 32'd0); chk32("rst_mwd", mem_wdata_a, 32'd0);
      chk32("rst_crd", cpu_a.rdata, 32'd0);  chk32("rst_drd", dma_a.rdata, 32'd0);
      chk1 ("rst_busy_b", busy_b, 1'b0);
      if (k == 0) step();
    end
    rst = 1'b0;                                   // cycle 0 of the CPU read
    for (int r = 1; r <= 4; r++) begin
      step();
      chk1("rd_mem_read", mem_read_a, r <= 2);
      if (r <= 2) chk32("rd_mem_addr", mem_addr_a, 32'h10);
      chk1("rd_owner", owner_a, 1'b0);
      chk1("rd_cack", cpu_a.ack, r == 3);
      chk1("rd_dack", dma_a.ack, 1'b0);
      if (r == 1) dma_a.req = 0;
      if (r == 3) chk32("rd_cpu_rdata", cpu_a.rdata, 32'h1234_5678);
    end
    cpu_a.req = 0; dma_a.req = 1;                 // cycle 0 of the DMA write
    for (int r = 1; r <= 4; r++) begin
      step();
      chk1("wr_mem_write", mem_write_a, r == 1);
      if (r == 1) begin
        chk32("wr_addr", mem_addr_a, 32'h20);
        chk32("wr_data", mem_wdata_a, 32'hDEAD_BEEF);
        chk1 ("wr_owner", owner_a, 1'b1);
      end
      chk1("wr_dack", dma_a.ack, r == 3);
      if (r == 3) begin
        chk32("wr_mem", mem_a[8], 32'hDEAD_BEEF);
        chk32("wr_drd_unchanged", dma_a.rdata, 32'd0);
      end
    end
    dma_a.req = 0;
    step();

    // Contention: both request, each re-requests after its ack.
    cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 32'h10;
    dma_a.req = 1; dma_a.we = 0; dma_a.addr = 32'h20;
    for (int r = 1; r <= 16; r++) begin
      step();
      chk1("ct_cack", cpu_a.ack, r == 3 || r == 11);
      chk1("ct_dack", dma_a.ack, r == 7 || r == 15);
      chk1("ct_owner", owner_a, ((r - 1) / 4) % 2 == 1);
      if (r == 3) chk32("ct_crd", cpu_a.rdata, 32'h1234_5678);
      if (r == 7) chk32("ct_drd", dma_a.rdata, 32'hDEAD_BEEF);
      if (cack_prev) cpu_a.req = 0; else if (!cpu_a.req) cpu_a.req = 1;
      if (dack_prev) dma_a.req = 0; else if (!dma_a.req) dma_a.req = 1;
    end
    cpu_a.req = 0; dma_a.req = 0;
    step(); step();

    // Reset in the second access cycle of a CPU read.
    cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 32'h10;
    step(); step();
    rst = 1'b1;
    step();
    chk1 ("ra_mem_read", mem_read_a, 1'b0);
    chk1 ("ra_busy", busy_a, 1'b0);
    chk1 ("ra_cack", cpu_a.ack, 1'b0);
    chk32("ra_crd_cleared", cpu_a.rdata, 32'd0);
    rst = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      step();
      chk1("ra_cack_re", cpu_a.ack, r == 3);
      if (r == 3) chk32("ra_crd_re", cpu_a.rdata, 32'h1234_5678);
    end
    step();
    cpu_a.req = 0;
    step();

    // MEM_LAT=1 instance: read then write.
    cpu_b.req = 1; cpu_b.we = 0; cpu_b.addr = 32'h10;
    step();
    chk1 ("l1_mrd_c1", mem_read_b, 1'b1);
    chk32("l1_addr", mem_addr_b, 32'h10);
    chk1 ("l1_cack_c1", cpu_b.ack, 1'b0);
    step();
    chk1 ("l1_mrd_c2", mem_read_b, 1'b0);
    chk1 ("l1_cack_c2", cpu_b.ack, 1'b1);
    chk32("l1_crd", cpu_b.rdata, 32'h1234_5678);
    step();
    chk1("l1_cack_c3", cpu_b.ack, 1'b0);
    chk1("l1_busy_c3", busy_b, 1'b0);
    cpu_b.req = 0;
    dma_b.req = 1; dma_b.we = 1; dma_b.addr = 32'h20; dma_b.wdata = 32'hCAFE_F00D;
    step();
    chk1("l1_mwr", mem_write_b, 1'b1);
    chk1("l1_dack_c1", dma_b.ack, 1'b0);
    step();
    chk1 ("l1_dack_c2", dma_b.ack, 1'b1);
    chk32("l1_drd", dma_b.rdata, 32'd0);
    chk32("l1_mem", mem_b[8], 32'hCAFE_F00D);
    step();
    dma_b.req = 0;
    step();

    // Randomized traffic with occasional resets, checked by the model each cycle.
    for (int n = 0; n < 2000; n++) begin
      rand_drive(cack_prev, cpu_a.req, cpu_a.we, cpu_a.addr, cpu_a.wdata, rq, w, a, d);
      cpu_a.req = rq; cpu_a.we = w; cpu_a.addr = a; cpu_a.wdata = d;
      rand_drive(dack_prev, dma_a.req, dma_a.we, dma_a.addr, dma_a.wdata, rq, w, a, d);
      dma_a.req = rq; dma_a.we = w; dma_a.addr = a; dma_a.wdata = d;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory of the multicycle MIPS between two requesters: the CPU controller/datapath (fetch, LW, SW) and a DMA/program-loader port. It arbitrates round-robin, latches the winning request, sequences the memory access with a fixed read latency, and returns data with a one-cycle acknowledge. It sits between both requesters and the memory macro, and is the only block that drives memory control.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory access cycles (>=1); read data valid on `mem_rdata` in the last access cycle
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU request; held with addr/we/wdata stable until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, registered
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as cpu_* for the DMA port
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high when state != IDLE
- owner  out  1  current or last granted port: 0 = CPU, 1 = DMA

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if no request, stay. With one request, grant it. With both, grant the port that is not `last_owner`.
- On grant, latch owner, we, addr, wdata into internal registers, load `cnt = MEM_LAT-1`, and move to ACCESS.
- ACCESS: `mem_addr` and `mem_wdata` are driven from the latched registers.
  - Read: `mem_read` = 1 on every ACCESS cycle.
  - Write: `mem_write` = 1 only on the first ACCESS cycle.
  - When `cnt == 0`:
    - If the access is a read, capture `mem_rdata` into the owner's rdata register.
    - Set `last_owner` to owner and go to DONE.
  - Otherwise, decrement `cnt`.
- DONE: pulse the owner's ack. Ignore requests. Go to IDLE.
- `*_rdata` changes only on a completed read for that port. A write leaves it unchanged.
- Outside ACCESS, `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are 0.
- Requester rule: deassert req in the cycle after ack. The next IDLE cycle then sees it low, so the other port wins under contention. A port can re-request one cycle after its ack cycle.
- Request inputs may change freely while not granted. Only values present in the grant cycle are used.

## Timing
- Reset values:
  - State IDLE, `cnt` 0.
  - `last_owner` = 1, so the CPU wins the first tie.
  - `owner` 0, `busy` 0.
  - All acks 0, all rdata 0, all mem_* outputs 0.
- Latency, with req first high in IDLE at cycle 0:
  - ACCESS occupies cycles 1..MEM_LAT.
  - Ack and valid rdata appear at cycle MEM_LAT+1.
  - Next grant is possible at cycle MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles.
- Simultaneous requests in IDLE: strict alternation based on `last_owner`.
- Reset mid-operation (any state): return to IDLE next cycle with reset values.
  - The aborted access is never acked.
  - A requester still holding req is re-arbitrated after reset, with the CPU first.
- The `cnt` width holds MEM_LAT-1. With MEM_LAT=1, ACCESS lasts exactly one cycle.

## Test plan
- **Reset:** rst high for 2 cycles with both reqs high. All outputs are 0 and `busy` = 0. After release, the CPU is granted in the first IDLE cycle.
- **CPU read, MEM_LAT=2:** model has mem[0x10] = 0x1234_5678; cpu_req at cycle 0 with addr 0x10.
  - `mem_read` = 1 with `mem_addr` = 0x10 in cycles 1–2.
  - `cpu_ack` = 1 in cycle 3 only, with `cpu_rdata` = 0x1234_5678.
  - `dma_ack` stays 0.
- **DMA write:** addr 0x20, data 0xDEAD_BEEF.
  - `mem_write` pulses in cycle 1 only, with those values.
  - `dma_ack` in cycle 3; model mem[0x20] = 0xDEAD_BEEF.
  - `dma_rdata` is unchanged.
- **Contention:** both ports request at cycle 0 and each re-requests after its ack. Acks occur in the order CPU@3, DMA@7, CPU@11, DMA@15, and `owner` toggles to match.
- **Reset mid-access:** rst high in cycle 2 of a CPU read.
  - `mem_read` = 0 and `busy` = 0 from the next cycle.
  - No `cpu_ack` is issued for the aborted read.
  - With req still held, the read re-completes with correct data 3 cycles after the first IDLE cycle following reset.
- **MEM_LAT=1 build:** a single read acks at cycle 2, with `mem_read` high only in cycle 1.
